// File: rtl/restoring_divider_seq.sv
// Sequential radix-2 restoring divider: 2N-bit dividend / N-bit divisor -> N-bit quotient and remainder.
// One quotient bit per clock, with valid/ready handshakes on both the operand and the result side.
module restoring_divider_seq #(
  parameter int N  = 32,
  parameter int CW = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*N-1:0]   dividend,
  input  logic [N-1:0]     divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     quotient,
  output logic [N-1:0]     remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         r_state;
  state_t         w_stateNext;

  logic [N-1:0]   r_rem;
  logic [N-1:0]   w_remNext;
  logic [N-1:0]   r_q;
  logic [N-1:0]   w_qNext;
  logic [N-1:0]   r_d;
  logic [N-1:0]   w_dNext;
  logic [CW-1:0]  r_count;
  logic [CW-1:0]  w_countNext;

  logic [N-1:0]   r_quotient;
  logic [N-1:0]   w_quotientNext;
  logic [N-1:0]   r_remainder;
  logic [N-1:0]   w_remainderNext;
  logic           r_divByZero;
  logic           w_divByZeroNext;
  logic           r_overflow;
  logic           w_overflowNext;

  logic [N:0]     w_shifted;
  logic [N:0]     w_trial;
  logic           w_trialNeg;
  logic [N-1:0]   w_remIter;
  logic [N-1:0]   w_qIter;
  logic           w_lastIter;
  logic           w_accept;
  logic           w_divisorZero;
  logic           w_quotientTooWide;

  // The partial remainder stays below the divisor, so its carry bit is always zero
  // and only N bits are kept; the trial subtraction still runs at N+1 bits.
  assign w_shifted  = {1'b0, r_rem, r_q[N-1]};
  assign w_trial    = w_shifted - {1'b0, r_d};
  assign w_trialNeg = w_trial[N];
  assign w_remIter  = w_trialNeg ? w_shifted[N-1:0] : w_trial[N-1:0];
  assign w_qIter    = {r_q[N-2:0], ~w_trialNeg};
  assign w_lastIter = (r_count == CW'(N - 1));

  assign w_accept          = in_valid && (r_state == IDLE);
  assign w_divisorZero     = (divisor == '0);
  assign w_quotientTooWide = (dividend[2*N-1:N] >= divisor);

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = (r_state == DONE);
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_divByZero;
  assign overflow    = r_overflow;

  always_comb begin
    w_stateNext     = r_state;
    w_remNext       = r_rem;
    w_qNext         = r_q;
    w_dNext         = r_d;
    w_countNext     = r_count;
    w_quotientNext  = r_quotient;
    w_remainderNext = r_remainder;
    w_divByZeroNext = r_divByZero;
    w_overflowNext  = r_overflow;

    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_divisorZero) begin
            w_stateNext     = DONE;
            w_quotientNext  = '1;
            w_remainderNext = dividend[N-1:0];
            w_divByZeroNext = 1'b1;
            w_overflowNext  = 1'b0;
          end else if (w_quotientTooWide) begin
            w_stateNext     = DONE;
            w_quotientNext  = '1;
            w_remainderNext = '0;
            w_divByZeroNext = 1'b0;
            w_overflowNext  = 1'b1;
          end else begin
            w_stateNext = RUN;
            w_remNext   = dividend[2*N-1:N];
            w_qNext     = dividend[N-1:0];
            w_dNext     = divisor;
            w_countNext = '0;
          end
        end
      end

      RUN: begin
        w_remNext   = w_remIter;
        w_qNext     = w_qIter;
        w_countNext = r_count + CW'(1);
        if (w_lastIter) begin
          w_stateNext     = DONE;
          w_quotientNext  = w_qIter;
          w_remainderNext = w_remIter;
          w_divByZeroNext = 1'b0;
          w_overflowNext  = 1'b0;
        end
      end

      DONE: begin
        if (out_ready) begin
          w_stateNext = IDLE;
        end
      end

      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // Reset discards any in-flight or held result, so nothing aborted is ever presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rem       <= '0;
      r_q         <= '0;
      r_d         <= '0;
      r_count     <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_divByZero <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_rem       <= w_remNext;
      r_q         <= w_qNext;
      r_d         <= w_dNext;
      r_count     <= w_countNext;
      r_quotient  <= w_quotientNext;
      r_remainder <= w_remainderNext;
      r_divByZero <= w_divByZeroNext;
      r_overflow  <= w_overflowNext;
    end
  end

endmodule

// File: tb/tb_restoring_divider_seq.sv
// Bench for restoring_divider_seq: directed vector table, handshake/reset corner sequences,
// and randomized operands checked against plain 64-bit arithmetic.
module tb_restoring_divider_seq;

  localparam int N  = 32;
  localparam int CW = 6;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [2*N-1:0] dividend;
  logic [N-1:0]  divisor;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  quotient;
  logic [N-1:0]  remainder;
  logic          div_by_zero;
  logic          overflow;

  int total;
  int bad;
  int unsigned cycleCount;

  restoring_divider_seq #(.N(N), .CW(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cycleCount = 0;
  always @(posedge clk) cycleCount <= cycleCount + 1;

  typedef struct {
    logic [63:0] dvd;
    logic [31:0] dvs;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    logic        ovf;
    int          lat;
  } vec_t;

  vec_t vecs[9];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Called at a negedge; returns at the negedge where out_valid is first seen.
  // lat counts negedges after the acceptance edge (0 = the cycle right after it).
  task automatic applyStimulus(input logic [63:0] dvd, input logic [31:0] dvs,
                               output int lat, output int unsigned acceptCycle, output bit ok);
    int waitCycles;
    ok = 1'b0;
    lat = 0;
    acceptCycle = 0;
    waitCycles = 0;
    while (!in_ready && waitCycles < 100) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!in_ready) begin
      checkOutput("in_ready_timeout", 64'(in_ready), 64'd1);
      return;
    end
    dividend = dvd;
    divisor  = dvs;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    acceptCycle = cycleCount;
    in_valid = 1'b0;
    dividend = {$urandom, $urandom};
    divisor  = $urandom;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) begin
      checkOutput("out_valid_timeout", 64'(out_valid), 64'd1);
      return;
    end
    ok = 1'b1;
  endtask

  task automatic releaseResult();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("post_handshake_out_valid", 64'(out_valid), 64'd0);
    checkOutput("post_handshake_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    int lat;
    int unsigned acc;
    int unsigned prevAcc;
    bit ok;
    bit sawValid;
    logic [31:0] holdQ;
    logic [31:0] holdR;
    logic [63:0] dvd;
    logic [31:0] dvs;
    logic [31:0] hi;
    logic [63:0] expQ;
    logic [63:0] expR;

    total = 0;
    bad = 0;
    vecs[0] = '{64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 32};
    vecs[1] = '{64'hFFFFFFFE_00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, 32};
    vecs[2] = '{64'h12345678_9ABCDEF0, 32'd0, 32'hFFFFFFFF, 32'h9ABCDEF0, 1'b1, 1'b0, 0};
    vecs[3] = '{64'h00000005_00000000, 32'd5, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b1, 0};
    vecs[4] = '{64'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 1'b0, 32};
    vecs[5] = '{64'd0, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 32};
    vecs[6] = '{64'h00000000_FFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, 32};
    vecs[7] = '{64'h00000001_00000000, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b1, 0};
    vecs[8] = '{64'h00000004_FFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'd4, 1'b0, 1'b0, 32};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_quotient", 64'(quotient), 64'd0);
    checkOutput("reset_remainder", 64'(remainder), 64'd0);
    checkOutput("reset_flags", 64'({div_by_zero, overflow}), 64'd0);

    $display("[TB] directed vector table");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].dvd, vecs[i].dvs, lat, acc, ok);
      if (ok) begin
        checkOutput($sformatf("vec%0d_quotient", i), 64'(quotient), 64'(vecs[i].q));
        checkOutput($sformatf("vec%0d_remainder", i), 64'(remainder), 64'(vecs[i].r));
        checkOutput($sformatf("vec%0d_div_by_zero", i), 64'(div_by_zero), 64'(vecs[i].dbz));
        checkOutput($sformatf("vec%0d_overflow", i), 64'(overflow), 64'(vecs[i].ovf));
        checkOutput($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
        if (!vecs[i].dbz && !vecs[i].ovf) begin
          checkOutput($sformatf("vec%0d_remultiply", i),
                      64'(quotient) * 64'(vecs[i].dvs) + 64'(remainder), vecs[i].dvd);
        end
        releaseResult();
      end
    end

    $display("[TB] backpressure hold");
    applyStimulus(64'd100, 32'd7, lat, acc, ok);
    if (ok) begin
      holdQ = quotient;
      holdR = remainder;
      checkOutput("bp_quotient", 64'(holdQ), 64'd14);
      for (int c = 0; c < 10; c++) begin
        if (c == 4) begin
          dividend = 64'd9999;
          divisor = 32'd10;
          in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
        @(negedge clk);
        checkOutput($sformatf("bp_out_valid_c%0d", c), 64'(out_valid), 64'd1);
        checkOutput($sformatf("bp_in_ready_c%0d", c), 64'(in_ready), 64'd0);
        checkOutput($sformatf("bp_quotient_c%0d", c), 64'(quotient), 64'd14);
        checkOutput($sformatf("bp_remainder_c%0d", c), 64'(remainder), 64'd2);
      end
      in_valid = 1'b0;
      releaseResult();
      @(negedge clk);
      checkOutput("bp_no_ghost_op", 64'(out_valid), 64'd0);
      checkOutput("bp_idle_in_ready", 64'(in_ready), 64'd1);
    end

    $display("[TB] reset during RUN");
    dividend = 64'h00000003_87654321;
    divisor = 32'hDEADBEEF;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (15) @(negedge clk);
    checkOutput("mid_run_not_done", 64'(out_valid), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
    checkOutput("abort_in_ready", 64'(in_ready), 64'd1);
    checkOutput("abort_quotient", 64'(quotient), 64'd0);
    checkOutput("abort_remainder", 64'(remainder), 64'd0);
    checkOutput("abort_flags", 64'({div_by_zero, overflow}), 64'd0);
    sawValid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) sawValid = 1'b1;
    end
    checkOutput("abort_result_never_shown", 64'(sawValid), 64'd0);
    applyStimulus(64'd1000, 32'd3, lat, acc, ok);
    if (ok) begin
      checkOutput("after_abort_quotient", 64'(quotient), 64'd333);
      checkOutput("after_abort_remainder", 64'(remainder), 64'd1);
      checkOutput("after_abort_latency", 64'(lat), 64'd32);
      releaseResult();
    end

    $display("[TB] random back-to-back regression");
    out_ready = 1'b1;
    prevAcc = 0;
    for (int i = 0; i < 1000; i++) begin
      dvs = $urandom;
      if (dvs == 0) dvs = 32'd1;
      hi = $urandom % dvs;
      dvd = {hi, 32'($urandom)};
      expQ = dvd / 64'(dvs);
      expR = dvd % 64'(dvs);
      applyStimulus(dvd, dvs, lat, acc, ok);
      if (!ok) break;
      checkOutput($sformatf("rand%0d_quotient", i), 64'(quotient), expQ);
      checkOutput($sformatf("rand%0d_remainder", i), 64'(remainder), expR);
      checkOutput($sformatf("rand%0d_identity", i),
                  64'(quotient) * 64'(dvs) + 64'(remainder), dvd);
      checkOutput($sformatf("rand%0d_rem_lt_div", i), 64'(remainder < dvs), 64'd1);
      checkOutput($sformatf("rand%0d_flags", i), 64'({div_by_zero, overflow}), 64'd0);
      if (i > 0) begin
        checkOutput($sformatf("rand%0d_spacing", i), 64'(acc - prevAcc), 64'(N + 2));
      end
      prevAcc = acc;
      @(negedge clk);
    end
    out_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
